// File: rtl/fifo_pkg.sv
// Shared defaults and types for the packet FIFO.
package fifo_pkg;

    // Default geometry: one 10-byte packet word per entry, eight entries.
    localparam int FIFO_DATA_W = 80;
    localparam int FIFO_DEPTH  = 8;

    typedef logic [FIFO_DATA_W-1:0] word_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one
// synchronous read port with a registered output. No reset on the array
// or on rdata so that the array maps onto block RAM.
module fifo_mem #(
    parameter int DATA_W = 80,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: capture the addressed entry; holds between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock FIFO for packet words. Pointer, occupancy and flag control
// live here; storage is delegated to fifo_mem.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    // Set by the first accepted read after reset; until then data_out is
    // forced to zero because the storage read register is never reset.
    logic              rd_valid_q, rd_valid_d;

    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] mem_rdata;

    // Flags come straight from the registered count, so they never glitch.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Each request is judged against the flags as they stood before the edge.
    assign wr_accept = write_en && !full;
    assign rd_accept = read_en  && !empty;

    // Next-state for pointers, occupancy and the output-valid mask.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;

        if (wr_accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_accept) begin
            rptr_d     = rptr_q + 1'b1;
            rd_valid_d = 1'b1;
        end

        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control registers; an asynchronous reset discards all stored words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // A read and a write never touch the same entry in one cycle: at full only
    // the read is accepted, and at empty only the write is.
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wptr_q),
        .wdata (data_in),
        .re    (rd_accept),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    assign data_out = rd_valid_q ? mem_rdata : '0;

endmodule : fifo

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed steps from the test plan followed by
// a randomized phase, all checked against a queue-based reference model.
module tb_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  write_en = 1'b0;
    logic  read_en = 1'b0;
    word_t data_in = '0;
    word_t data_out;
    logic  full;
    logic  empty;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the stored words in order, plus the expected output.
    word_t model_q[$];
    word_t exp_dout = '0;

    fifo dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    // ASCII packet "PKT000000<i>", byte 0 = 'P' on bits [7:0].
    function automatic word_t pkt(input int i);
        word_t w;
        w = '0;
        w[7:0]   = 8'h50;
        w[15:8]  = 8'h4B;
        w[23:16] = 8'h54;
        for (int b = 3; b < 9; b++) w[8*b +: 8] = 8'h30;
        w[79:72] = 8'(8'h30 + i);
        return w;
    endfunction

    function automatic word_t rnd_word();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    task automatic check(input string tag);
        n_cmp++;
        assert (data_out === exp_dout) else begin
            n_err++;
            $error("FAIL %s data_out got %h want %h", tag, data_out, exp_dout);
        end
        n_cmp++;
        assert (full === (model_q.size() == DEPTH)) else begin
            n_err++;
            $error("FAIL %s full got %b want %b", tag, full, model_q.size() == DEPTH);
        end
        n_cmp++;
        assert (empty === (model_q.size() == 0)) else begin
            n_err++;
            $error("FAIL %s empty got %b want %b", tag, empty, model_q.size() == 0);
        end
    endtask

    // One clock with the given requests; model applies the FIFO rules.
    task automatic step(input bit we, input bit re, input word_t d, input string tag);
        bit wa, ra;
        write_en = we;
        read_en  = re;
        data_in  = d;
        @(posedge clk);
        wa = we && (model_q.size() < DEPTH);
        ra = re && (model_q.size() > 0);
        if (ra) exp_dout = model_q.pop_front();
        if (wa) model_q.push_back(d);
        #1;
        check(tag);
        $display("step %-10s we=%0b re=%0b din=%h dout=%h full=%0b empty=%0b occ=%0d",
                 tag, we, re, d, data_out, full, empty, model_q.size());
    endtask

    // Assert reset between edges, check it took effect before any edge,
    // hold it across one edge, then release away from the edge.
    task automatic async_reset(input string tag);
        write_en = 1'b0;
        read_en  = 1'b0;
        #2;
        rst = 1'b1;
        model_q.delete();
        exp_dout = '0;
        #1;
        check({tag, "_imm"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, "_rel"});
        $display("reset %s", tag);
    endtask

    initial begin
        word_t xw;
        int pw, pr;
        for (int b = 0; b < 10; b++) xw[8*b +: 8] = 8'h58;

        // Reset for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset");

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, pkt(i), "fill");
        step(1'b1, 1'b0, xw, "overflow");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "drain");
        step(1'b0, 1'b1, '0, "underflow");
        step(1'b0, 1'b0, '0, "idle");

        // Wrap and simultaneous.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd_word(), "wrap_w5");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "wrap_r3");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, rnd_word(), "wrap_w6");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rnd_word(), "simul");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, "final_drn");

        // Reset in the middle of operation discards stored words.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rnd_word(), "pre_rst");
        step(1'b0, 1'b1, '0, "pre_rst_rd");
        async_reset("mid_op");
        step(1'b0, 1'b1, '0, "post_rst");

        // Randomized traffic with shifting write/read bias.
        for (int i = 0; i < 400; i++) begin
            pw = (i / 50) % 2 ? 30 : 70;
            pr = 100 - pw;
            if (i == 237) async_reset("rand");
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, rnd_word(), "random");
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, "end_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo
